// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared constants and state encoding for the mux scan serializer.
//   DATA_W   : parallel word width (fixed at 8)
//   SEL_W    : select counter width, clog2(DATA_W)
//   SEL_LAST : select index of the final data bit
//   state_e  : serializer FSM states (PARITY only reachable with PARITY_EN)
package mux_scan_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

endpackage : mux_scan_pkg

// File: rtl/scan_sel_mux.sv
// scan_sel_mux
//   Combinational DATA_W:1 bit select out of the held word.
//   Ports:
//     hold    in  DATA_W  held parallel word
//     sel     in  SEL_W   bit index into hold
//     bit_out out 1       hold[sel]
module scan_sel_mux
  import mux_scan_pkg::*;
(
  input  logic [DATA_W-1:0] hold,
  input  logic [SEL_W-1:0]  sel,
  output logic              bit_out
);

  always_comb begin
    bit_out = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (sel == SEL_W'(i)) begin
        bit_out = hold[i];
      end
    end
  end

endmodule : scan_sel_mux

// File: rtl/mux_scan_serializer.sv
// mux_scan_serializer
//   Accepts one parallel byte over valid/ready, then steps a 3-bit select
//   counter 0..7 and emits the held word LSB first on a serial valid/ready
//   stream. The live select index is exported for a downstream mux/monitor.
//   Optional macro PARITY_EN appends an even-parity beat (XOR of the word)
//   after the sel=7 data beat.
//
//   Ports:
//     clk        in   system clock, rising edge
//     rst        in   synchronous active-high reset
//     in_data    in   parallel word to serialize
//     in_valid   in   in_data valid
//     in_ready   out  word can be accepted this cycle (combinational on
//                     ser_ready during the final beat)
//     ser_out    out  current serial bit
//     ser_valid  out  ser_out valid
//     ser_ready  in   consumer takes ser_out this cycle
//     sel        out  current select index into the held word
//     last       out  current beat is the final beat of the word
//     busy       out  a word is held and not fully sent
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no word held, in_ready=1 (unless in reset)
//   SHIFT  | emitting data bits hold[sel], sel 0..7
//   PARITY | emitting XOR of hold, sel parked at 7 (PARITY_EN only)
module mux_scan_serializer
  import mux_scan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic [SEL_W-1:0]  sel,
  output logic              last,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              ser_valid_q, ser_valid_d;
  logic              busy_q, busy_d;
  logic              last_q, last_d;

  logic beat;
  logic final_phase;
  logic accept;
  logic mux_bit;

  scan_sel_mux u_sel_mux (
    .hold    (hold_q),
    .sel     (sel_q),
    .bit_out (mux_bit)
  );

  // The beat that ends a word: the parity beat when enabled, otherwise
  // the sel=7 data beat. Only on this beat may a new word slip in.
`ifdef PARITY_EN
  assign final_phase = (state_q == PARITY);
`else
  assign final_phase = (state_q == SHIFT) && (sel_q == SEL_LAST);
`endif

  assign beat     = ser_valid_q & ser_ready;
  assign in_ready = ~rst & ((state_q == IDLE) | (final_phase & ser_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    sel_d   = sel_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = in_data;
          sel_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (beat) begin
          if (sel_q != SEL_LAST) begin
            sel_d = sel_q + SEL_W'(1);
          end else begin
`ifdef PARITY_EN
            // sel stays parked at 7 through the parity beat
            state_d = PARITY;
`else
            sel_d = '0;
            if (accept) begin
              hold_d  = in_data;
              state_d = SHIFT;
            end else begin
              state_d = IDLE;
            end
`endif
          end
        end
      end

`ifdef PARITY_EN
      PARITY: begin
        if (beat) begin
          sel_d = '0;
          if (accept) begin
            hold_d  = in_data;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
`endif

      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // Status outputs are registered from the next-state values so they line
  // up with state_q/sel_q in the same cycle.
  always_comb begin
    ser_valid_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
`ifdef PARITY_EN
    last_d      = (state_d == PARITY);
`else
    last_d      = (state_d == SHIFT) && (sel_d == SEL_LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      sel_q       <= '0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sel_q       <= sel_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
    end
  end

  // ser_out is forced low outside an active word so a stale hold never
  // leaks onto the serial line while idle.
`ifdef PARITY_EN
  assign ser_out = ser_valid_q & ((state_q == PARITY) ? ^hold_q : mux_bit);
`else
  assign ser_out = ser_valid_q & mux_bit;
`endif

  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign last      = last_q;
  assign sel       = sel_q;

endmodule : mux_scan_serializer

// File: tb/tb_mux_scan_serializer.sv
// tb_mux_scan_serializer
//   Directed and random stimulus against a beat-count reference model.
//   Build with +define+PARITY_EN to cover the parity variant.
module tb_mux_scan_serializer;

`ifdef PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       ser_ready = 1'b1;
  logic [2:0] sel;
  logic       last;
  logic       busy;

  mux_scan_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .sel       (sel),
    .last      (last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: remaining beats of the current word (0 = idle).
  int         cnt      = 0;
  logic [7:0] word     = 8'h00;
  int         acc_cnt  = 0;
  logic       prev_acc = 1'b0;

  logic [15:0] cap    = 16'h0;
  logic        par_obs = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return !rst && (cnt == 0 || (cnt == 1 && ser_ready));
  endfunction

  task automatic check_outputs();
    int   idx;
    logic e_out;
    int   e_sel;
    idx   = NB - cnt;
    e_sel = (cnt == 0) ? 0 : ((idx > 7) ? 7 : idx);
    e_out = (cnt == 0) ? 1'b0 : ((idx < 8) ? word[idx] : ^word);
    chk("in_ready",  16'(in_ready),  16'(model_ready()));
    chk("ser_valid", 16'(ser_valid), 16'(cnt > 0));
    chk("busy",      16'(busy),      16'(cnt > 0));
    chk("last",      16'(last),      16'(cnt == 1));
    chk("sel",       16'(sel),       16'(e_sel));
    chk("ser_out",   16'(ser_out),   16'(e_out));
    if (cnt > 0 && ser_ready) begin
      if (idx < 8) cap = {ser_out, cap[15:1]};
      else         par_obs = ser_out;
    end
  endtask

  task automatic model_step();
    logic acc;
    acc = in_valid && model_ready();
    if (rst) begin
      cnt      = 0;
      prev_acc = 1'b0;
    end else begin
      if (cnt > 0 && ser_ready) cnt--;
      if (acc) begin
        word = in_data;
        cnt  = NB;
        acc_cnt++;
      end
      prev_acc = acc;
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic sr);
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    in_data   = d;
    ser_ready = sr;
    #1 check_outputs();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic       rv, rr, rsr;
    logic [7:0] rd;

    @(posedge clk);
    model_step();

    // reset then idle
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // single word A5
    cap = '0;
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    repeat (NB + 1) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("word_a5", {8'h00, cap[15:8]}, 16'h00A5);

    // back-to-back 0F then F0
    cap     = '0;
    acc_cnt = 0;
    repeat (2 * NB + 2)
      cyc(1'b0, acc_cnt < 2, (acc_cnt == 0) ? 8'h0F : 8'hF0, 1'b1);
    chk("b2b_words", cap, 16'hF00F);
    chk("b2b_count", 16'(acc_cnt), 16'd2);

    // backpressure on 3C at sel=2
    cap = '0;
    cyc(1'b0, 1'b1, 8'h3C, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    repeat (NB - 1) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("word_3c", {8'h00, cap[15:8]}, 16'h003C);

    // reset mid-word at sel=4, then a clean 01
    cyc(1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cap = '0;
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    repeat (NB + 1) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("word_01", {8'h00, cap[15:8]}, 16'h0001);

`ifdef PARITY_EN
    cyc(1'b0, 1'b1, 8'h07, 1'b1);
    repeat (NB + 1) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("parity_07", 16'(par_obs), 16'd1);
    cyc(1'b0, 1'b1, 8'h03, 1'b1);
    repeat (NB + 1) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("parity_03", 16'(par_obs), 16'd0);
`endif

    // random traffic; upstream holds a pending word until accepted
    rv = 1'b0;
    rd = 8'h00;
    repeat (3000) begin
      if (!(rv && !prev_acc)) begin
        rv = ($urandom_range(0, 9) < 6);
        rd = 8'($urandom);
      end
      rsr = ($urandom_range(0, 3) != 0);
      rr  = ($urandom_range(0, 199) == 0);
      cyc(rr, rv, rd, rsr);
      if (rr) rv = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_mux_scan_serializer
